// File: rtl/imem_encoder.sv
// Instruction-memory encoder/loader: packs instruction descriptors into 32-bit
// words and writes them to consecutive IMEM addresses, one word per two cycles.
module imem_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        in_op,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_cmd,
  input  logic              in_s,
  input  logic              in_i,
  input  logic              in_l,
  input  logic              in_u,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [11:0]       in_src2,
  input  logic [23:0]       in_imm24,
  output logic              imem_wen,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0]        C_OP_DATA   = 2'd0;
  localparam logic [1:0]        C_OP_MEMORY = 2'd1;
  localparam logic [1:0]        C_OP_BRANCH = 2'd2;
  localparam logic [1:0]        C_OP_ILL    = 2'd3;
  localparam logic [3:0]        C_COND_ILL  = 4'hF;
  localparam logic [ADDR_W:0]   C_FULL      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   C_CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   C_CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] C_ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Packs one descriptor into the controller's instruction word format.
  function automatic logic [31:0] encode_word(
    input logic [1:0]  op,
    input logic [3:0]  cond,
    input logic [3:0]  cmd,
    input logic        s,
    input logic        i,
    input logic        l,
    input logic        u,
    input logic [3:0]  rn,
    input logic [3:0]  rd,
    input logic [11:0] src2,
    input logic [23:0] imm24
  );
    logic [31:0] word;
    case (op)
      C_OP_DATA:   word = {cond, 2'b00, i, cmd, s, rn, rd, src2};
      C_OP_MEMORY: word = {cond, 2'b01, ~i, 1'b1, u, 1'b0, 1'b0, l, rn, rd, src2};
      C_OP_BRANCH: word = {cond, 2'b10, 1'b1, l, imm24};
      default:     word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_waddr;
  logic [31:0]         r_wdata;
  logic                r_last;
  logic [ADDR_W:0]     r_count;
  logic                r_err;
  logic                w_ready;
  logic                w_hs;
  logic                w_illegal;
  logic                w_restart;
  logic [ADDR_W:0]     w_count_inc;

  assign w_ready     = (r_state == S_ACCEPT) && !r_count[ADDR_W];
  assign w_hs        = w_ready && in_valid;
  assign w_illegal   = (in_op == C_OP_ILL) || (in_cond == C_COND_ILL);
  // A write in flight always completes, so restart is masked in WRITE.
  assign w_restart   = load_start && (r_state != S_WRITE);
  assign w_count_inc = r_count + C_CNT_ONE;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection; restart takes priority over a same-cycle handshake.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (load_start) w_next_state = S_ACCEPT;
        else            w_next_state = S_IDLE;
      end
      S_ACCEPT: begin
        if (load_start)               w_next_state = S_ACCEPT;
        else if (w_hs && !w_illegal)  w_next_state = S_WRITE;
        else if (w_hs && in_last)     w_next_state = S_DONE;
        else                          w_next_state = S_ACCEPT;
      end
      S_WRITE: begin
        if (r_last || (w_count_inc == C_FULL)) w_next_state = S_DONE;
        else                                   w_next_state = S_ACCEPT;
      end
      S_DONE: begin
        if (load_start) w_next_state = S_ACCEPT;
        else            w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Session datapath: address/count/error tracking and the captured word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= {ADDR_W{1'b0}};
      r_waddr <= {ADDR_W{1'b0}};
      r_wdata <= 32'h0000_0000;
      r_last  <= 1'b0;
      r_count <= C_CNT_ZERO;
      r_err   <= 1'b0;
    end else if (w_restart) begin
      r_addr  <= start_addr;
      r_count <= C_CNT_ZERO;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_hs) begin
      if (w_illegal) begin
        r_err <= 1'b1;
      end else begin
        r_wdata <= encode_word(in_op, in_cond, in_cmd, in_s, in_i, in_l, in_u,
                               in_rn, in_rd, in_src2, in_imm24);
        r_waddr <= r_addr;
        r_last  <= in_last;
      end
    end else if (r_state == S_WRITE) begin
      r_addr  <= r_addr + C_ADDR_ONE;
      r_count <= w_count_inc;
    end else begin
      r_last  <= r_last;
    end
  end

  assign in_ready   = w_ready;
  assign imem_wen   = (r_state == S_WRITE);
  assign imem_addr  = r_waddr;
  assign imem_wdata = r_wdata;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign count      = r_count;
  assign err        = r_err;

endmodule

// File: tb/tb_imem_encoder.sv
// Directed self-checking bench for imem_encoder (built with ADDR_W=2 so the
// wrap and full conditions are reachable in a few descriptors).
module tb_imem_encoder;
  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          load_start;
  logic [AW-1:0] start_addr;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [1:0]    in_op;
  logic [3:0]    in_cond;
  logic [3:0]    in_cmd;
  logic          in_s;
  logic          in_i;
  logic          in_l;
  logic          in_u;
  logic [3:0]    in_rn;
  logic [3:0]    in_rd;
  logic [11:0]   in_src2;
  logic [23:0]   in_imm24;
  logic          imem_wen;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic          err;

  int checks = 0;
  int errors = 0;

  imem_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_op(in_op),
    .in_cond(in_cond), .in_cmd(in_cmd), .in_s(in_s), .in_i(in_i), .in_l(in_l),
    .in_u(in_u), .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2),
    .in_imm24(in_imm24), .imem_wen(imem_wen), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .count(count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] a);
    load_start = 1'b1;
    start_addr = a;
    tick();
    load_start = 1'b0;
  endtask

  task automatic set_desc(input logic [1:0] op, input logic [3:0] cond, input logic [3:0] cmd,
                          input logic s, input logic i, input logic l, input logic u,
                          input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] src2,
                          input logic [23:0] imm24, input logic last);
    in_op = op; in_cond = cond; in_cmd = cmd; in_s = s; in_i = i; in_l = l; in_u = u;
    in_rn = rn; in_rd = rd; in_src2 = src2; in_imm24 = imm24; in_last = last;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, imem_wen, imem_addr, imem_wdata, busy, done, count, err} !== 44'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b wen=%b addr=%0d wdata=%h busy=%b done=%b cnt=%0d err=%b, required all 0",
               in_ready, imem_wen, imem_addr, imem_wdata, busy, done, count, err);
    end
    #13 rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got rdy=%b busy=%b, required 0 0", in_ready, busy);
    end
  endtask

  task automatic test_data_single();
    pulse_start(2'd0);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: got rdy=%b busy=%b, required 1 1", in_ready, busy);
    end
    set_desc(2'd0, 4'hE, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 4'h1, 12'h005, 24'h0, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (imem_wen !== 1'b1 || imem_addr !== 2'd0 || imem_wdata !== 32'hE282_1005 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL data_write: got wen=%b addr=%0d wdata=%h rdy=%b, required 1 0 e2821005 0",
               imem_wen, imem_addr, imem_wdata, in_ready);
    end
    tick();
    checks++;
    if (done !== 1'b1 || count !== 3'd1 || err !== 1'b0 || imem_wen !== 1'b0) begin
      errors++;
      $display("FAIL data_done: got done=%b cnt=%0d err=%b wen=%b, required 1 1 0 0", done, count, err, imem_wen);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || imem_wdata !== 32'hE282_1005) begin
      errors++;
      $display("FAIL data_idle: got done=%b busy=%b wdata=%h, required 0 0 e2821005", done, busy, imem_wdata);
    end
  endtask

  task automatic test_mem_branch();
    pulse_start(2'd0);
    set_desc(2'd1, 4'hE, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h4, 4'h3, 12'h008, 24'h0, 1'b0);
    in_valid = 1'b1;
    tick();
    checks++;
    if (imem_wen !== 1'b1 || imem_addr !== 2'd0 || imem_wdata !== 32'hE594_3008) begin
      errors++;
      $display("FAIL mem_write: got wen=%b addr=%0d wdata=%h, required 1 0 e5943008", imem_wen, imem_addr, imem_wdata);
    end
    set_desc(2'd2, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 12'h0, 24'h000010, 1'b1);
    tick();
    tick();
    in_valid = 1'b0;
    checks++;
    if (imem_wen !== 1'b1 || imem_addr !== 2'd1 || imem_wdata !== 32'hEB00_0010) begin
      errors++;
      $display("FAIL branch_write: got wen=%b addr=%0d wdata=%h, required 1 1 eb000010", imem_wen, imem_addr, imem_wdata);
    end
    tick();
    checks++;
    if (done !== 1'b1 || count !== 3'd2) begin
      errors++;
      $display("FAIL mem_branch_done: got done=%b cnt=%0d, required 1 2", done, count);
    end
    tick();
  endtask

  task automatic test_wrap_full();
    logic [AW-1:0] exp_addr [4];
    int hs;
    int nw;
    bit w;
    bit seen_done;
    exp_addr[0] = 2'd3; exp_addr[1] = 2'd0; exp_addr[2] = 2'd1; exp_addr[3] = 2'd2;
    hs = 0; nw = 0; seen_done = 1'b0;
    pulse_start(2'd3);
    set_desc(2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 4'h2, 12'h000, 24'h0, 1'b0);
    in_valid = 1'b1;
    for (int c = 0; c < 30 && !seen_done; c++) begin
      if (imem_wen) begin
        checks++;
        if (nw >= 4 || imem_addr !== exp_addr[nw] || imem_wdata !== (32'h0011_2000 | 32'(nw))) begin
          errors++;
          $display("FAIL wrap_write%0d: got addr=%0d wdata=%h, required addr=%0d wdata=%h",
                   nw, imem_addr, imem_wdata, exp_addr[nw % 4], 32'h0011_2000 | 32'(nw));
        end
        nw++;
      end
      if (done) begin
        seen_done = 1'b1;
        checks++;
        if (count !== 3'd4) begin
          errors++;
          $display("FAIL wrap_count: got %0d, required 4", count);
        end
      end
      if (hs >= 4 && in_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_ready: got in_ready=%b after 4 handshakes, required 0", in_ready);
      end
      w = in_valid && in_ready;
      tick();
      if (w) begin
        hs++;
        in_src2 = 12'(hs);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (!seen_done || hs != 4 || nw != 4) begin
      errors++;
      $display("FAIL wrap_summary: got done_seen=%b handshakes=%0d writes=%0d, required 1 4 4", seen_done, hs, nw);
    end
    tick();
  endtask

  task automatic test_illegal();
    int nw;
    nw = 0;
    pulse_start(2'd1);
    set_desc(2'd3, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h0, 24'h0, 1'b0);
    in_valid = 1'b1;
    tick();
    if (imem_wen) nw++;
    checks++;
    if (err !== 1'b1 || count !== 3'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_op: got err=%b cnt=%0d rdy=%b, required 1 0 1", err, count, in_ready);
    end
    set_desc(2'd0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h0, 24'h0, 1'b0);
    tick();
    if (imem_wen) nw++;
    set_desc(2'd0, 4'hE, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 4'h1, 12'h005, 24'h0, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++;
    if (imem_wen !== 1'b1 || imem_addr !== 2'd1 || imem_wdata !== 32'hE282_1005) begin
      errors++;
      $display("FAIL illegal_then_legal: got wen=%b addr=%0d wdata=%h, required 1 1 e2821005", imem_wen, imem_addr, imem_wdata);
    end
    nw++;
    tick();
    checks++;
    if (done !== 1'b1 || count !== 3'd1 || err !== 1'b1 || nw != 1) begin
      errors++;
      $display("FAIL illegal_done: got done=%b cnt=%0d err=%b writes=%0d, required 1 1 1 1", done, count, err, nw);
    end
    tick();
    pulse_start(2'd0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got err=%b, required 0", err);
    end
    // An illegal descriptor carrying last ends the session without any write.
    set_desc(2'd3, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h0, 24'h0, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || imem_wen !== 1'b0 || err !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL illegal_last: got done=%b wen=%b err=%b cnt=%0d, required 1 0 1 0", done, imem_wen, err, count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [3];
    int k;
    int nw;
    int last_cyc;
    bit w;
    bit seen_done;
    exp_w[0] = 32'hE1A0_00A0; exp_w[1] = 32'hE1A0_10A1; exp_w[2] = 32'hE1A0_20A2;
    k = 0; nw = 0; last_cyc = -1; seen_done = 1'b0;
    pulse_start(2'd0);
    set_desc(2'd0, 4'hE, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h0A0, 24'h0, 1'b0);
    in_valid = 1'b1;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      if (imem_wen) begin
        checks++;
        if (nw >= 3 || imem_wdata !== exp_w[nw % 3] || in_ready !== 1'b0 ||
            imem_addr !== 2'(nw) || (last_cyc >= 0 && c - last_cyc != 2)) begin
          errors++;
          $display("FAIL b2b_write%0d: got wdata=%h addr=%0d rdy=%b gap=%0d, required wdata=%h addr=%0d rdy=0 gap=2",
                   nw, imem_wdata, imem_addr, in_ready, c - last_cyc, exp_w[nw % 3], nw);
        end
        last_cyc = c;
        nw++;
      end
      if (done) seen_done = 1'b1;
      w = in_valid && in_ready;
      tick();
      if (w) begin
        k++;
        if (k < 3) begin
          in_rd = 4'(k);
          in_src2 = 12'h0A0 + 12'(k);
          in_last = (k == 2);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (!seen_done || nw != 3 || k != 3 || count !== 3'd3) begin
      errors++;
      $display("FAIL b2b_summary: got done_seen=%b writes=%0d handshakes=%0d cnt=%0d, required 1 3 3 3",
               seen_done, nw, k, count);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    pulse_start(2'd2);
    set_desc(2'd2, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 12'h0, 24'h123456, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (imem_wen !== 1'b1 || imem_addr !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset_write: got wen=%b addr=%0d, required 1 2", imem_wen, imem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, imem_wen, imem_addr, imem_wdata, busy, done, count, err} !== 44'd0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b wen=%b addr=%0d wdata=%h busy=%b done=%b cnt=%0d err=%b, required all 0",
               in_ready, imem_wen, imem_addr, imem_wdata, busy, done, count, err);
    end
    #3 rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || imem_wen !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got rdy=%b busy=%b wen=%b, required 0 0 0", in_ready, busy, imem_wen);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load_start = 1'b0;
    start_addr = '0;
    in_valid = 1'b0;
    set_desc(2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h0, 24'h0, 1'b0);
    test_reset();
    test_data_single();
    test_mem_branch();
    test_wrap_full();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_encoder.md
# imem_encoder

Instruction-memory encoder and loader: the write-side counterpart of the instruction decoder. It accepts instruction descriptors (class, condition, command, register and operand fields) over a valid/ready handshake, packs each one into the 32-bit instruction word format the controller decodes, and writes the words to instruction memory at consecutive addresses. The block sits between the testbench or boot source and the IMEM write port, and is used to build programs for the processor core.

## Interface
Parameters:
- ADDR_W, 6, IMEM word-address width; capacity is 2^ADDR_W words.

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse that begins a load session.
- start_addr  in  ADDR_W  first IMEM address, sampled on load_start.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  block can accept a descriptor.
- in_last  in  1  marks the final descriptor of the session.
- in_op  in  2  instruction class: 0 DATA, 1 MEMORY, 2 BRANCH, 3 illegal.
- in_cond  in  4  condition code; 4'hF is illegal.
- in_cmd  in  4  DATA command.
- in_s  in  1  DATA set-flags bit.
- in_i  in  1  1 = immediate operand.
- in_l  in  1  MEMORY: 1 = load. BRANCH: 1 = link.
- in_u  in  1  MEMORY: 1 = add offset.
- in_rn, in_rd  in  4 each  register fields.
- in_src2  in  12  operand / offset field.
- in_imm24  in  24  branch offset.
- imem_wen  out  1  IMEM write strobe.
- imem_addr  out  ADDR_W  IMEM write address.
- imem_wdata  out  32  encoded instruction word.
- busy  out  1  asserted in every state except IDLE.
- done  out  1  one-cycle pulse when a session ends.
- count  out  ADDR_W+1  number of words written in the current session.
- err  out  1  sticky illegal-descriptor flag; cleared by load_start.

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE → ACCEPT on load_start. This loads the address register from start_addr and clears count and err.
- ACCEPT:
  - in_ready = 1 while count < 2^ADDR_W.
  - A handshake (in_valid & in_ready) registers the encoded word and in_last.
  - A legal descriptor moves to WRITE.
  - An illegal descriptor (in_op=3 or in_cond=F) sets err and is discarded: no write, count unchanged. If in_last was set, go to DONE; otherwise stay in ACCEPT.
- WRITE:
  - imem_wen = 1 for exactly one cycle, with the registered address and data.
  - The address increments modulo 2^ADDR_W (wraps to 0); count increments.
  - Next state is DONE if the registered in_last is set or count reaches 2^ADDR_W; otherwise ACCEPT.
- DONE: done = 1 for one cycle, then IDLE.
- load_start is honoured in IDLE, ACCEPT and DONE (session restart). It is ignored in WRITE, so a write in flight always completes.
- When count = 2^ADDR_W the block is full: in_ready = 0 and the session ends via DONE.
- Encoding, by in_op:
  - DATA: [31:28]=cond, [27:26]=00, [25]=in_i, [24:21]=cmd, [20]=s, [19:16]=rn, [15:12]=rd, [11:0]=src2.
  - MEMORY: cond, 01, [25]=~in_i, [24]=1 (P), [23]=u, [22]=0, [21]=0, [20]=l, rn, rd, src2.
  - BRANCH: cond, 10, [25]=1, [24]=l, [23:0]=imm24.
  - Unused descriptor fields are ignored.

## Timing
- Reset values: state IDLE, in_ready 0, imem_wen 0, imem_addr 0, imem_wdata 0, busy 0, done 0, count 0, err 0.
- A descriptor handshaken at edge N is written at edge N+1 (imem_wen is high in cycle N+1). Peak throughput is one word per 2 cycles.
- in_ready is a registered state decode; it is 0 in WRITE, DONE and IDLE.
- imem_wdata and imem_addr hold their values outside WRITE; imem_wen is the only strobe.
- done is asserted one cycle after the final WRITE or the final illegal handshake.
- Reset asserted mid-session aborts it immediately. All outputs return to their reset values asynchronously; a partial write is not guaranteed.

## Test plan
- load_start with start_addr=0, then DATA descriptor cond=E, I=1, cmd=4, S=0, rn=2, rd=1, src2=0x005, last=1 → one write of 0xE2821005 at addr 0, count=1, done pulse, err=0.
- MEMORY descriptor cond=E, I=1, U=1, L=1, rn=4, rd=3, src2=0x008, then BRANCH descriptor cond=E, link=1, imm24=0x000010 with last=1 → 0xE5943008 at addr 0, then 0xEB000010 at addr 1.
- Wrap and full with ADDR_W=2, start_addr=3, five valid descriptors, last never set → writes at addresses 3, 0, 1, 2; in_ready drops after the 4th handshake; count=4; done pulses; the 5th descriptor is never accepted.
- Illegal descriptors: in_op=3, then cond=F, then a legal descriptor with last=1 → err=1, only one write, count=1; the next load_start clears err.
- Back-to-back in_valid held high for 3 descriptors → imem_wen pulses on alternate cycles, in_ready is 0 on each WRITE cycle, no descriptor is lost or duplicated.
- rst_n asserted low during WRITE → all outputs go to their reset values without waiting for a clock edge; after release the block is in IDLE and in_ready=0 until load_start.
